snake_move_ctrl: RTL and testbench

Movement scheduler for the snake datapath. Converts keyboard scan codes into a legal heading (no 180° reversal) and times each snake step with a level-dependent tick counter. Issues each step to the body/position datapath via a req/ack handshake. Sits between the game_state FSM (init_snake, screen_pause) and the snake body datapath; speeds up as food is eaten.

---
 rtl/snake_pkg.sv | 58 +++++
 rtl/snake_tick_timer.sv | 68 ++++++
 rtl/snake_move_ctrl.sv | 154 +++++++++++++++
 tb/tb_snake_move_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake movement scheduler.
//
// Contents:
//   dir_t         heading encoding (UP=0, RIGHT=1, DOWN=2, LEFT=3)
//   state_t       scheduler FSM states (IDLE, RUN, REQ)
//   KEY_*         PS/2 make codes for WASD and the arrow keys
//   key_dec_t     result of decoding one scan code
//   is_reversal() true when d is the 180 degree opposite of r
//   decode_key()  maps a scan code to a heading (hit=0 for unknown codes)
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_REQ  = 2'd2
  } state_t;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;

  typedef struct packed {
    logic hit;
    dir_t dir;
  } key_dec_t;

  // Opposite headings differ only in bit 1 with this encoding.
  function automatic logic is_reversal(input logic [1:0] d, input logic [1:0] r);
    return (d ^ r) == 2'b10;
  endfunction

  function automatic key_dec_t decode_key(input logic [7:0] code);
    key_dec_t k;
    k.hit = 1'b1;
    k.dir = DIR_RIGHT;
    case (code)
      KEY_W, KEY_UP:       k.dir = DIR_UP;
      KEY_D, KEY_RIGHT:    k.dir = DIR_RIGHT;
      KEY_S, KEY_DOWN:     k.dir = DIR_DOWN;
      KEY_A, KEY_LEFT:     k.dir = DIR_LEFT;
      default:             k.hit = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/snake_tick_timer.sv
// Pausable step timer for the snake scheduler.
//
// The step period is BASE_PERIOD - level*PERIOD_STEP, evaluated as a signed
// CNT_W+1 bit value and clamped to MIN_PERIOD. The period is captured while
// restart is high, so a level change only affects the next counting run.
//
// Ports:
//   clk      system clock
//   resetn   synchronous active-low reset
//   run      counter may advance (scheduler is in RUN)
//   pause    freeze the counter
//   restart  hold counter at 0 and capture the period for the current level
//   level    current speed level
//   expire   high on the cycle whose clock edge completes one period
module snake_tick_timer #(
  parameter int CNT_W       = 25,
  parameter int BASE_PERIOD = 6250000,
  parameter int PERIOD_STEP = 500000,
  parameter int MIN_PERIOD  = 1250000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       run,
  input  logic       pause,
  input  logic       restart,
  input  logic [3:0] level,
  output logic       expire
);

  localparam logic signed [CNT_W:0] BASE_S = (CNT_W + 1)'(BASE_PERIOD);
  localparam logic signed [CNT_W:0] MIN_S  = (CNT_W + 1)'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]      STEP_U = CNT_W'(PERIOD_STEP);
  localparam logic [CNT_W-1:0]      MIN_U  = CNT_W'(MIN_PERIOD);

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      period_q;
  logic [CNT_W-1:0]      period_next;
  logic [CNT_W-1:0]      last;
  logic signed [CNT_W:0] diff;

  // A negative difference is also below MIN_S in signed compare, so one
  // comparison covers both clamp cases.
  always_comb begin
    diff = BASE_S - $signed({1'b0, CNT_W'(level) * STEP_U});
    if (diff < MIN_S) begin
      period_next = MIN_U;
    end else begin
      period_next = diff[CNT_W-1:0];
    end
  end

  assign last   = period_q - CNT_W'(1);
  assign expire = run & ~pause & ~restart & (cnt == last);

  always_ff @(posedge clk) begin
    if (!resetn || restart) begin
      cnt      <= '0;
      period_q <= period_next;
    end else if (run && !pause) begin
      if (cnt == last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/snake_move_ctrl.sv
// Movement scheduler for the snake datapath.
//
// Turns keyboard scan codes into a legal pending heading (no 180 degree
// reversal), times each step with a level-dependent tick, and hands each step
// to the body datapath. The level rises every GROW_PER_LEVEL food pulses.
//
// Handshake: step_req rises together with a stable step_dir and both hold
// until the datapath returns step_ack=1 in a cycle where step_req=1; the step
// is committed on that edge and step_req falls the following cycle. step_ack
// while step_req=0 has no effect. init_snake withdraws a pending request
// without committing it.
//
// Ports:
//   clk, resetn   system clock, synchronous active-low reset
//   init_snake    return to start-of-game state (same effect as reset)
//   screen_pause  freeze step timing and ignore keys
//   key_valid     one-cycle strobe qualifying key_code
//   key_code      PS/2 make code
//   grow          one-cycle food-eaten pulse
//   step_req      request to advance one cell
//   step_dir      heading of the requested step
//   step_ack      datapath accepted the step
//   level         current speed level
//
// The FSM state is held in 'state' (state_t) for observation.
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter int CNT_W          = 25,
  parameter int BASE_PERIOD    = 6250000,
  parameter int PERIOD_STEP    = 500000,
  parameter int MIN_PERIOD     = 1250000,
  parameter int GROW_PER_LEVEL = 4,
  parameter int MAX_LEVEL      = 15
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       init_snake,
  input  logic       screen_pause,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       grow,
  output logic       step_req,
  output logic [1:0] step_dir,
  input  logic       step_ack,
  output logic [3:0] level
);

  localparam int GW = (GROW_PER_LEVEL > 1) ? $clog2(GROW_PER_LEVEL) : 1;
  localparam logic [GW-1:0] GROW_LAST = GW'(GROW_PER_LEVEL - 1);
  localparam logic [3:0]    LEVEL_TOP = 4'(MAX_LEVEL);

  state_t        state;
  logic [1:0]    dir_cur;
  logic [1:0]    dir_pend;
  logic [GW-1:0] grow_cnt;

  key_dec_t      key;
  logic [1:0]    ref_dir;
  logic          key_take;
  logic          expire;
  logic          timer_run;
  logic          timer_restart;

  assign timer_run     = (state == ST_RUN);
  assign timer_restart = (state != ST_RUN) | init_snake;

  snake_tick_timer #(
    .CNT_W       (CNT_W),
    .BASE_PERIOD (BASE_PERIOD),
    .PERIOD_STEP (PERIOD_STEP),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .run     (timer_run),
    .pause   (screen_pause),
    .restart (timer_restart),
    .level   (level),
    .expire  (expire)
  );

  // Reference heading for reversal filtering. On the edge that enters REQ
  // the new step_dir is the current dir_pend, so a key in that same cycle is
  // judged against dir_pend rather than dir_cur.
  always_comb begin
    key = decode_key(key_code);
    if (state == ST_REQ) begin
      ref_dir = step_dir;
    end else if (expire) begin
      ref_dir = dir_pend;
    end else begin
      ref_dir = dir_cur;
    end
    key_take = key_valid && !screen_pause && key.hit &&
               (key.dir != ref_dir) && !is_reversal(key.dir, ref_dir);
  end

  always_ff @(posedge clk) begin
    if (!resetn || init_snake) begin
      state    <= ST_IDLE;
      step_req <= 1'b0;
      step_dir <= DIR_RIGHT;
      dir_cur  <= DIR_RIGHT;
      dir_pend <= DIR_RIGHT;
      level    <= '0;
      grow_cnt <= '0;
    end else begin
      if (key_take) begin
        dir_pend <= key.dir;
      end

      // Food counting runs in RUN and REQ, independent of pause.
      if (grow && state != ST_IDLE) begin
        if (grow_cnt == GROW_LAST) begin
          grow_cnt <= '0;
          if (level != LEVEL_TOP) begin
            level <= level + 4'd1;
          end
        end else begin
          grow_cnt <= grow_cnt + GW'(1);
        end
      end

      case (state)
        ST_IDLE: begin
          if (!screen_pause) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // step_dir samples dir_pend before any same-cycle key update.
          if (expire) begin
            step_dir <= dir_pend;
            step_req <= 1'b1;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (step_ack) begin
            dir_cur  <= step_dir;
            step_req <= 1'b0;
            state    <= ST_RUN;
          end
        end
        default: begin
          state    <= ST_IDLE;
          step_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Bench for snake_move_ctrl with a small-period configuration
// (BASE 20, STEP 4, MIN 8, 2 grows per level).
module tb_snake_move_ctrl;

  localparam int BASE = 20;
  localparam int STEP = 4;
  localparam int MINP = 8;
  localparam int GPL  = 2;
  localparam int MAXL = 15;

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_RIGHT = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       init_snake = 1'b0;
  logic       screen_pause = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       grow = 1'b0;
  logic       step_ack = 1'b0;
  logic       step_req;
  logic [1:0] step_dir;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  snake_move_ctrl #(
    .BASE_PERIOD    (BASE),
    .PERIOD_STEP    (STEP),
    .MIN_PERIOD     (MINP),
    .GROW_PER_LEVEL (GPL)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .init_snake   (init_snake),
    .screen_pause (screen_pause),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .grow         (grow),
    .step_req     (step_req),
    .step_dir     (step_dir),
    .step_ack     (step_ack),
    .level        (level)
  );

  // ---------------- reference model ----------------
  // Phases: idle, counting down to the next step, waiting for ack.
  typedef enum int {M_IDLE, M_COUNT, M_WAIT} mphase_t;
  mphase_t m_phase = M_IDLE;
  int  m_left  = 0;   // unpaused cycles left until the step is requested
  bit  m_req   = 1'b0;
  int  m_dir   = 1;
  int  m_cur   = 1;
  int  m_pend  = 1;
  int  m_level = 0;
  int  m_grow  = 0;

  function automatic int m_period(input int lvl);
    int p;
    p = BASE - lvl * STEP;
    return (p < MINP) ? MINP : p;
  endfunction

  function automatic int m_key_dir(input logic [7:0] c);
    case (c)
      8'h1D, 8'h75: return 0;
      8'h23, 8'h74: return 1;
      8'h1B, 8'h72: return 2;
      8'h1C, 8'h6B: return 3;
      default:      return -1;
    endcase
  endfunction

  task automatic model_step();
    int kd, refd, np, nl, ng;
    if (!resetn || init_snake) begin
      m_phase = M_IDLE; m_left = 0; m_req = 1'b0;
      m_dir = 1; m_cur = 1; m_pend = 1; m_level = 0; m_grow = 0;
      return;
    end
    kd = m_key_dir(key_code);
    if (m_phase == M_WAIT) refd = m_dir;
    else if (m_phase == M_COUNT && !screen_pause && m_left == 1) refd = m_pend;
    else refd = m_cur;
    np = m_pend;
    if (key_valid && !screen_pause && kd >= 0 && kd != refd && kd != (refd + 2) % 4)
      np = kd;
    nl = m_level;
    ng = m_grow;
    if (grow && m_phase != M_IDLE) begin
      ng++;
      if (ng == GPL) begin
        ng = 0;
        if (nl < MAXL) nl++;
      end
    end
    case (m_phase)
      M_IDLE: if (!screen_pause) begin m_phase = M_COUNT; m_left = m_period(m_level); end
      M_COUNT: if (!screen_pause) begin
        if (m_left == 1) begin m_phase = M_WAIT; m_req = 1'b1; m_dir = m_pend; end
        else m_left--;
      end
      M_WAIT: if (step_ack) begin
        m_cur = m_dir; m_req = 1'b0; m_phase = M_COUNT; m_left = m_period(m_level);
      end
      default: m_phase = M_IDLE;
    endcase
    m_pend = np; m_level = nl; m_grow = ng;
  endtask

  // ---------------- driver tasks ----------------
  // One clock: advance the model with the inputs the DUT is about to
  // sample, then return at the following negedge with outputs settled.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic [7:0] c);
    key_valid = 1'b1;
    key_code  = c;
    tick();
    key_valid = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic pulse_grow(input int count);
    for (int i = 0; i < count; i++) begin
      grow = 1'b1;
      tick();
      grow = 1'b0;
      tick();
    end
  endtask

  // Ticks until step_req is seen high; n = ticks taken, or -1 on timeout.
  task automatic wait_req(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (step_req !== 1'b1 && n < limit);
    if (step_req !== 1'b1) n = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      init_snake = 1'($urandom_range(0, 1));
      key_valid  = 1'b1;
      key_code   = 8'h1D;
      grow       = 1'b1;
      step_ack   = 1'b1;
      tick();
      checks++;
      if (step_req !== 1'b0 || step_dir !== D_RIGHT || level !== 4'd0) begin
        errors++;
        $display("FAIL reset_values got req=%0b dir=%0d lvl=%0d exp req=0 dir=1 lvl=0",
                 step_req, step_dir, level);
      end
    end
    init_snake = 1'b0; key_valid = 1'b0; key_code = 8'h00; grow = 1'b0; step_ack = 1'b0;
  endtask

  task automatic test_free_run();
    int n;
    step_ack = 1'b1;
    resetn   = 1'b1;
    // One IDLE cycle, then 20 counting cycles.
    wait_req(100, n);
    checks++;
    if (n !== 21) begin errors++; $display("FAIL first_step_latency got %0d exp 21", n); end
    checks++;
    if (step_dir !== D_RIGHT) begin errors++; $display("FAIL first_step_dir got %0d exp 1", step_dir); end
    for (int k = 0; k < 2; k++) begin
      wait_req(100, n);
      checks++;
      if (n !== 21) begin errors++; $display("FAIL step_interval got %0d exp 21", n); end
    end
  endtask

  task automatic test_anti_reversal();
    int n;
    tick();
    press(8'h1C);
    press(8'h1D);
    wait_req(100, n);
    checks++;
    if (n < 0 || step_dir !== D_UP) begin
      errors++; $display("FAIL left_then_up got dir=%0d n=%0d exp dir=0", step_dir, n);
    end
    tick();
    press(8'h1B);
    wait_req(100, n);
    checks++;
    if (n < 0 || step_dir !== D_UP) begin
      errors++; $display("FAIL down_rejected got dir=%0d n=%0d exp dir=0", step_dir, n);
    end
    tick();
    press(8'h29);
    wait_req(100, n);
    checks++;
    if (n < 0 || step_dir !== D_UP) begin
      errors++; $display("FAIL unknown_code got dir=%0d n=%0d exp dir=0", step_dir, n);
    end
  endtask

  task automatic test_handshake_hold();
    int n;
    step_ack = 1'b0;
    tick();
    wait_req(100, n);
    checks++;
    if (n < 0) begin errors++; $display("FAIL hold_sync got timeout exp step_req"); end
    screen_pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      key_valid = (i == 0);
      key_code  = 8'h23;
      tick();
      checks++;
      if (step_req !== 1'b1 || step_dir !== D_UP) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d got req=%0b dir=%0d exp req=1 dir=0", i, step_req, step_dir);
      end
    end
    key_valid = 1'b0;
    step_ack  = 1'b1;
    tick();
    step_ack  = 1'b0;
    checks++;
    if (step_req !== 1'b0) begin errors++; $display("FAIL ack_drop got %0b exp 0", step_req); end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (step_req !== 1'b0) begin errors++; $display("FAIL paused_no_req got %0b exp 0", step_req); end
    screen_pause = 1'b0;
    wait_req(100, n);
    checks++;
    if (n !== 20) begin errors++; $display("FAIL restart_after_pause got %0d exp 20", n); end
    checks++;
    if (step_dir !== 2'(m_dir) || step_dir !== D_UP) begin
      errors++; $display("FAIL paused_key_ignored got dir=%0d exp 0", step_dir);
    end
  endtask

  task automatic test_level();
    int n;
    step_ack = 1'b1;
    pulse_grow(6);
    checks++;
    if (level !== 4'd3) begin errors++; $display("FAIL level_after_6 got %0d exp 3", level); end
    wait_req(100, n);
    wait_req(100, n);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL period_level3 got %0d exp 9", n); end
    pulse_grow(2);
    checks++;
    if (level !== 4'd4) begin errors++; $display("FAIL level_after_8 got %0d exp 4", level); end
    wait_req(100, n);
    wait_req(100, n);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL period_clamp got %0d exp 9", n); end
    pulse_grow(22);
    checks++;
    if (level !== 4'd15) begin errors++; $display("FAIL level_after_30 got %0d exp 15", level); end
    pulse_grow(2);
    checks++;
    if (level !== 4'd15) begin errors++; $display("FAIL level_saturate got %0d exp 15", level); end
    wait_req(100, n);
    wait_req(100, n);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL period_max_level got %0d exp 9", n); end
  endtask

  task automatic test_init_mid_req();
    int n;
    step_ack = 1'b0;
    tick();
    wait_req(100, n);
    init_snake = 1'b1;
    key_valid  = 1'b1;
    key_code   = 8'h1D;
    tick();
    key_valid  = 1'b0;
    checks++;
    if (step_req !== 1'b0 || level !== 4'd0 || step_dir !== D_RIGHT) begin
      errors++;
      $display("FAIL init_mid_req got req=%0b lvl=%0d dir=%0d exp req=0 lvl=0 dir=1", step_req, level, step_dir);
    end
    init_snake = 1'b0;
    // IDLE cycle plus 20 counting cycles at level 0.
    wait_req(100, n);
    checks++;
    if (n !== 21 || step_dir !== D_RIGHT) begin
      errors++; $display("FAIL after_init got n=%0d dir=%0d exp n=21 dir=1", n, step_dir);
    end
  endtask

  task automatic test_pause();
    int n;
    step_ack = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    screen_pause = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    screen_pause = 1'b0;
    wait_req(100, n);
    checks++;
    if (1 + 5 + 7 + n !== 21 + 7) begin
      errors++; $display("FAIL pause_delay got %0d exp %0d", 1 + 5 + 7 + n, 28);
    end
  endtask

  task automatic find_expire_cycle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_phase == M_COUNT && m_left == 1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    step_ack = 1'b1;
    find_expire_cycle(ok);
    press(8'h1D);
    checks++;
    if (!ok || step_req !== 1'b1 || step_dir !== D_RIGHT) begin
      errors++; $display("FAIL key_on_entry got ok=%0b req=%0b dir=%0d exp 1 1 1", ok, step_req, step_dir);
    end
    wait_req(100, n);
    checks++;
    if (n < 0 || step_dir !== D_UP) begin
      errors++; $display("FAIL key_on_entry_next got dir=%0d exp 0", step_dir);
    end
    tick();
    press(8'h1C);
    find_expire_cycle(ok);
    press(8'h23);
    checks++;
    if (!ok || step_req !== 1'b1 || step_dir !== D_LEFT) begin
      errors++; $display("FAIL entry_ref_dir got ok=%0b req=%0b dir=%0d exp 1 1 3", ok, step_req, step_dir);
    end
    wait_req(100, n);
    checks++;
    if (n < 0 || step_dir !== D_LEFT) begin
      errors++; $display("FAIL entry_reversal_rejected got dir=%0d exp 3", step_dir);
    end
  endtask

  task automatic test_random();
    logic [7:0] codes [10];
    codes = '{8'h1D, 8'h75, 8'h23, 8'h74, 8'h1B, 8'h72, 8'h1C, 8'h6B, 8'h29, 8'h00};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      resetn       = ($urandom_range(0, 299) != 0);
      init_snake   = ($urandom_range(0, 199) == 0);
      screen_pause = ($urandom_range(0, 4) == 0);
      key_valid    = ($urandom_range(0, 3) == 0);
      key_code     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                 : codes[$urandom_range(0, 9)];
      grow         = ($urandom_range(0, 5) == 0);
      step_ack     = ($urandom_range(0, 1) == 1);
      tick();
      checks++;
      if (step_req !== m_req || step_dir !== 2'(m_dir) || level !== 4'(m_level)) begin
        errors++;
        $display("FAIL random cyc=%0d got req=%0b dir=%0d lvl=%0d exp req=%0b dir=%0d lvl=%0d",
                 cyc, step_req, step_dir, level, m_req, m_dir, m_level);
      end
    end
    resetn = 1'b1; init_snake = 1'b0; screen_pause = 1'b0;
    key_valid = 1'b0; grow = 1'b0; step_ack = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_free_run();
    test_anti_reversal();
    test_handshake_hold();
    test_level();
    test_init_mid_req();
    test_pause();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
